// File: rtl/lut_arbiter.sv
// Two-requester arbiter in front of a shared combinational-read LUT.
// Round-robin in IDLE, optional ownership lock with an idle timeout, 1-cycle response.

module lut_arbiter_rsp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gnt,
  input  logic [DATA_WIDTH-1:0] lut_q,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= 1'b0;
      rdata    <= '0;
    end else begin
      vld_pipe <= gnt;
      if (gnt) rdata <= lut_q;
    end
  end

  assign rvalid = vld_pipe;
endmodule

module lut_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  a_lock,
  output logic                  a_ready,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_lock,
  output logic                  b_ready,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_q,
  output logic [1:0]            owner
);
  localparam int NUM_REQ = 2;
  localparam logic [7:0] TIMEOUT = 8'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10} state_t;

  state_t                                state;
  logic                                  rr_b;      // 1: most recent winner was B
  logic [7:0]                            idle_cnt;
  logic [7:0]                            idle_cnt_nxt;
  logic                                  own_lock;
  logic [NUM_REQ-1:0]                    valid, lock, gnt, rvalid;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    rdata;

  assign valid = {b_valid, a_valid};
  assign lock  = {b_lock, a_lock};
  assign addr  = {b_addr, a_addr};

  // Grants are suppressed while reset is high so a beat in that cycle is dropped.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      case (state)
        IDLE:    gnt = (valid == 2'b11) ? (rr_b ? 2'b01 : 2'b10) : valid;
        OWN_A:   gnt[0] = valid[0];
        OWN_B:   gnt[1] = valid[1];
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    lut_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) lut_addr = addr[i];
  end

  assign own_lock     = (state == OWN_B) ? lock[1] : lock[0];
  assign idle_cnt_nxt = idle_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_b     <= 1'b1;
      idle_cnt <= '0;
    end else begin
      if (|gnt) rr_b <= gnt[1];
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (gnt[0] && lock[0])      state <= OWN_A;
          else if (gnt[1] && lock[1]) state <= OWN_B;
        end
        OWN_A, OWN_B: begin
          // Only the owner can be granted here, so any grant is an owner beat.
          if (|gnt) begin
            idle_cnt <= '0;
            if (!own_lock) state <= IDLE;
          end else if (idle_cnt_nxt == TIMEOUT) begin
            idle_cnt <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt_nxt;
          end
        end
        default: begin
          idle_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    lut_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk    (clk),
      .reset  (reset),
      .gnt    (gnt[g]),
      .lut_q  (lut_q),
      .rvalid (rvalid[g]),
      .rdata  (rdata[g])
    );
  end

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign a_rvalid = rvalid[0];
  assign b_rvalid = rvalid[1];
  assign a_rdata  = rdata[0];
  assign b_rdata  = rdata[1];
  assign owner    = state;
endmodule

// File: tb/tb_lut_arbiter.sv
// Scoreboard bench for lut_arbiter: directed scenarios then random traffic
// against a cycle-level reference model of the arbitration rules.

module tb_lut_arbiter;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0, a_lock = 1'b0, b_valid = 1'b0, b_lock = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic          a_ready, a_rvalid, b_ready, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata, lut_q;
  logic [AW-1:0] lut_addr;
  logic [1:0]    owner;

  lut_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_lock(a_lock), .a_ready(a_ready),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_addr(b_addr), .b_lock(b_lock), .b_ready(b_ready),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .lut_addr(lut_addr), .lut_q(lut_q), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lut_fn(input logic [AW-1:0] ad);
    return DW'(ad) + DW'(16'h0100);
  endfunction

  assign lut_q = lut_fn(lut_addr);

  typedef struct { logic [DW-1:0] data; int cyc; } rsp_t;
  rsp_t qa[$], qb[$];
  logic [DW-1:0] last_a = '0, last_b = '0;
  int n_chk = 0, n_fail = 0, cyc = 0;

  // reference model: owner (0 none, 1 A, 2 B), last winner (0 A, 1 B), idle cycles
  int m_own = 0, m_last = 1, m_idle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit av, input logic [AW-1:0] aa, input bit al,
                      input bit bv, input logic [AW-1:0] ba, input bit bl);
    int g;
    @(negedge clk);
    reset = rst; a_valid = av; a_addr = aa; a_lock = al;
    b_valid = bv; b_addr = ba; b_lock = bl;
    #1;
    if (rst) begin
      m_own = 0; m_last = 1; m_idle = 0;
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
      check("rst_owner", owner, 0);
      check("rst_ready", {a_ready, b_ready}, 0);
      return;
    end
    if (m_own == 1)           g = av ? 1 : 0;
    else if (m_own == 2)      g = bv ? 2 : 0;
    else if (av && bv)        g = (m_last == 1) ? 1 : 2;
    else if (av)              g = 1;
    else if (bv)              g = 2;
    else                      g = 0;
    check("a_ready", a_ready, g == 1);
    check("b_ready", b_ready, g == 2);
    check("lut_addr", lut_addr, g == 1 ? aa : (g == 2 ? ba : '0));
    check("owner", owner, m_own);
    if (g == 1) begin qa.push_back('{lut_fn(aa), cyc}); m_last = 0; end
    if (g == 2) begin qb.push_back('{lut_fn(ba), cyc}); m_last = 1; end
    if (m_own == 0) begin
      if (g == 1 && al)      m_own = 1;
      else if (g == 2 && bl) m_own = 2;
    end else if (g != 0) begin
      m_idle = 0;
      if (!(g == 1 ? al : bl)) m_own = 0;
    end else begin
      m_idle++;
      if (m_idle == TO) begin m_own = 0; m_idle = 0; end
    end
  endtask

  // monitor: responses are due exactly one cycle after their grant
  initial forever begin
    bit ea, eb;
    rsp_t r;
    @(posedge clk); #1;
    cyc++;
    ea = (qa.size() > 0) && (qa[0].cyc == cyc - 1);
    eb = (qb.size() > 0) && (qb[0].cyc == cyc - 1);
    check("a_rvalid", a_rvalid, ea);
    check("b_rvalid", b_rvalid, eb);
    if (ea) begin r = qa.pop_front(); last_a = r.data; end
    if (eb) begin r = qb.pop_front(); last_b = r.data; end
    check("a_rdata", a_rdata, last_a);
    check("b_rdata", b_rdata, last_b);
  end

  initial begin
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    // tie after reset: A,B,A,B
    repeat (4) step(0, 1, 8'h10, 0, 1, 8'h20, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // A holds a 3-beat lock while B waits
    step(0, 1, 8'h01, 1, 1, 8'h30, 0);
    step(0, 1, 8'h02, 1, 1, 8'h30, 0);
    step(0, 1, 8'h03, 0, 1, 8'h30, 0);
    step(0, 0, 8'h77, 0, 1, 8'h30, 0);
    // timeout release after TO idle cycles
    step(0, 1, 8'h05, 1, 1, 8'h31, 0);
    repeat (TO) step(0, 0, 8'h55, 0, 1, 8'h31, 1);
    step(0, 0, 0, 0, 1, 8'h32, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // expiry race: owner beat on the last idle cycle restarts the count
    step(0, 1, 8'h06, 1, 0, 0, 0);
    repeat (TO - 1) step(0, 0, 0, 0, 1, 8'h33, 0);
    step(0, 1, 8'h07, 1, 1, 8'h33, 0);
    repeat (TO - 1) step(0, 0, 0, 0, 1, 8'h33, 0);
    step(0, 1, 8'h08, 0, 1, 8'h33, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // single requester streaming
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, AW'(8'h40 + i), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a B lock with a beat in flight
    step(0, 0, 0, 0, 1, 8'h50, 1);
    step(0, 1, 8'h09, 0, 1, 8'h51, 1);
    step(1, 1, 8'h09, 0, 1, 8'h52, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 800; i++)
      step(($urandom % 97) == 0, ($urandom % 3) != 0, AW'($urandom), ($urandom % 3) == 0,
           ($urandom % 3) != 0, AW'($urandom), ($urandom % 3) == 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    check("drain", qa.size() + qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lut_arbiter.md
LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, LUT word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, LUT address width.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 16, idle cycles after which a held lock is released (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port a_valid  input  1  requester A lookup request.
REQ-007 SHALL have port a_addr  input  ADDR_WIDTH  requester A LUT address.
REQ-008 SHALL have port a_lock  input  1  requester A asks to keep ownership after this beat.
REQ-009 SHALL have port a_ready  output  1  requester A beat accepted this cycle.
REQ-010 SHALL have port a_rvalid  output  1  requester A response valid (one-cycle pulse).
REQ-011 SHALL have port a_rdata  output  DATA_WIDTH  requester A response word.
REQ-012 SHALL have ports b_valid, b_addr, b_lock, b_ready, b_rvalid, b_rdata, identical to A's, for requester B.
REQ-013 SHALL have port lut_addr  output  ADDR_WIDTH  address to the shared combinational-read LUT.
REQ-014 SHALL have port lut_q  input  DATA_WIDTH  LUT read data, valid in the same cycle as lut_addr.
REQ-015 SHALL have port owner  output  2  00 none, 01 A locked, 10 B locked.

Function
REQ-016 A beat SHALL transfer on a cycle where x_valid and x_ready are both 1; at most one of a_ready/b_ready SHALL be 1 per cycle.
REQ-017 x_ready SHALL be combinational from the valids, the state and the round-robin pointer; it SHALL be 0 whenever x_valid is 0.
REQ-018 lut_addr SHALL equal the granted requester's address in a transfer cycle and 0 otherwise.
REQ-019 On a transfer in cycle N, x_rdata SHALL register lut_q at the end of N and x_rvalid SHALL be 1 in cycle N+1 only; latency is exactly 1 cycle.
REQ-020 x_rdata SHALL hold its last value until the next response to that requester.
REQ-021 Throughput SHALL be one beat per cycle aggregate, with no bubble between back-to-back grants.
REQ-022 FSM states SHALL be IDLE, OWN_A, OWN_B; owner SHALL encode them as 00/01/10.
REQ-023 IDLE: if only one valid, grant it; if both valid, grant the requester that did not win the most recent grant (rr pointer).
REQ-024 Every grant SHALL update the rr pointer to the winner, in every state.
REQ-025 IDLE -> OWN_x on a transfer from x with x_lock=1; otherwise remain IDLE.
REQ-026 OWN_x: only x SHALL be grantable; the other requester's ready SHALL be 0 regardless of its valid.
REQ-027 OWN_x -> IDLE on a transfer from x with x_lock=0; that beat is still served normally.
REQ-028 OWN_x SHALL count consecutive cycles with x_valid=0; when the count reaches LOCK_TIMEOUT the FSM SHALL go to IDLE on that edge and clear the count.
REQ-029 The idle count SHALL clear on every transfer from x; if x_valid=1 in the cycle the count would expire, the transfer wins and no release occurs.
REQ-030 The release of a lock (by REQ-027 or REQ-028) SHALL take effect next cycle; the other requester cannot be granted in the release cycle.
REQ-031 Address and lock inputs are sampled only in transfer cycles; changes while ready=0 have no effect.

Reset
REQ-032 While reset=1: FSM=IDLE, owner=00, idle count=0, rr pointer=B (A wins the first tie), a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
REQ-033 A reset asserted mid-lock SHALL drop ownership immediately and suppress any pending rvalid; a beat in the reset cycle is discarded.
REQ-034 After deassertion, grants SHALL be possible on the first clock edge.

Verification
REQ-035 Tie: a_valid=b_valid=1 for 4 cycles after reset, addrs 0x10/0x20, LUT q=addr+0x100 -> grants A,B,A,B; a_rdata=0x0110, b_rdata=0x0120, each rvalid 1 cycle after its grant.
REQ-036 Lock: A sends 3 beats (lock=1,1,0) at 0x01..0x03 with b_valid=1 throughout -> b_ready=0 for 3 cycles, owner=01 then 00, B granted in the 4th cycle.
REQ-037 Timeout: LOCK_TIMEOUT=4, A locks then a_valid=0, b_valid=1 -> owner returns to 00 after 4 idle cycles; B granted the cycle after.
REQ-038 Expiry race: A valid in the cycle its count reaches 3 (of 4) -> A granted, count clears, owner stays 01.
REQ-039 Reset mid-lock: reset during OWN_B with a beat in flight -> owner=00, b_rvalid=0 and b_rdata=0 next cycle.
REQ-040 Single requester streaming: b_valid=1 for 8 cycles, a_valid=0 -> 8 consecutive grants, 8 consecutive b_rvalid pulses, lut_addr=0 when no grant.
